vga_pixel_fifo_param: RTL

Parametrised synchronous pixel FIFO between the frame-fetch/memory side and the VGA timing/output stage. It is the successor to the fixed 8-deep, 32-to-24-bit pixel FIFO. It generalises depth, input width and pixel-slice position. It adds full/almost-full/almost-empty flags, a read-valid strobe, a synchronous flush, and full-with-simultaneous-read pass-through.

---
 rtl/vga_pixel_fifo_param.sv | 120 ++++++++++++
 1 files changed

// File: rtl/vga_pixel_fifo_param.sv
// Parametrised synchronous pixel FIFO between frame fetch and the VGA output stage.
// Optional sticky overflow/underflow detection is built when VGA_FIFO_ERR_EN is defined.
module vga_pixel_fifo_param #(
   parameter int unsigned IN_W      = 32,
   parameter int unsigned PIX_W     = 24,
   parameter int unsigned PIX_LSB   = 8,
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned AF_THRESH = 6,
   parameter int unsigned AE_THRESH = 2,
   parameter int unsigned CNT_W     = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             wr_en,
   input  logic [IN_W-1:0]  data_in,
   input  logic             rd_en,
   output logic [PIX_W-1:0] data_pixel,
   output logic             rd_valid,
   output logic             empty,
   output logic             full,
   output logic             almost_empty,
   output logic             almost_full,
   output logic [CNT_W-1:0] level,
   output logic [CNT_W-1:0] freeslots,
   output logic             overflow,
   output logic             underflow
);

   localparam int unsigned     PTR_W   = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_L = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AF_L    = CNT_W'(AF_THRESH);
   localparam logic [CNT_W-1:0] AE_L    = CNT_W'(AE_THRESH);
   localparam logic [CNT_W-1:0] ZERO_L  = '0;

   logic [PIX_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
   logic [CNT_W-1:0] level_d;
   logic [PIX_W-1:0] data_pixel_d;
   logic [PIX_W-1:0] pixel_slice;
   logic             rd_acc, wr_acc, rd_valid_d;
   logic             unused_data_in;

   // Only the pixel slice is stored; remaining bits of data_in are intentionally dropped.
   assign pixel_slice    = data_in[PIX_LSB +: PIX_W];
   assign unused_data_in = ^data_in;

   // Next-state: accept rules on pre-edge state, flush overrides requests.
   always_comb begin
      rd_acc       = rd_en & ~empty;
      wr_acc       = wr_en & (~full | rd_en);
      wr_ptr_d     = wr_ptr;
      rd_ptr_d     = rd_ptr;
      level_d      = level;
      data_pixel_d = data_pixel;
      rd_valid_d   = 1'b0;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (wr_acc) wr_ptr_d = wr_ptr + PTR_W'(1);
         if (rd_acc) begin
            rd_ptr_d     = rd_ptr + PTR_W'(1);
            data_pixel_d = mem[rd_ptr];
            rd_valid_d   = 1'b1;
         end
         if (wr_acc && !rd_acc)      level_d = level + CNT_W'(1);
         else if (rd_acc && !wr_acc) level_d = level - CNT_W'(1);
      end
   end

   // State and registered flags derived from the next level.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         level        <= '0;
         data_pixel   <= '0;
         rd_valid     <= 1'b0;
         empty        <= 1'b1;
         full         <= (ZERO_L == DEPTH_L);
         almost_empty <= (ZERO_L <= AE_L);
         almost_full  <= (ZERO_L >= AF_L);
         freeslots    <= DEPTH_L;
      end else begin
         wr_ptr       <= wr_ptr_d;
         rd_ptr       <= rd_ptr_d;
         level        <= level_d;
         data_pixel   <= data_pixel_d;
         rd_valid     <= rd_valid_d;
         empty        <= (level_d == ZERO_L);
         full         <= (level_d == DEPTH_L);
         almost_empty <= (level_d <= AE_L);
         almost_full  <= (level_d >= AF_L);
         freeslots    <= DEPTH_L - level_d;
      end
   end

   // Storage array has no reset; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (!rst && !flush && wr_acc) mem[wr_ptr] <= pixel_slice;
   end

`ifdef VGA_FIFO_ERR_EN
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= overflow  | (wr_en & full & ~rd_en);
         underflow <= underflow | (rd_en & empty);
      end
   end
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

endmodule
